// File: rtl/path_test_pkg.sv
// rtl/path_test_pkg.sv - shared FSM state type and width helpers for the path delay tester
package path_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_LAUNCH,
        ST_WAIT,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    localparam int FAIL_CNT_W = 16;

    // Bits needed to index n items (never less than one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed for a counter holding values 0..n.
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/path_stage_chain.sv
// rtl/path_stage_chain.sv - one channel: DEPTH registered stages with optional inversion and stuck-at override
module path_stage_chain
    import path_test_pkg::*;
#(
    parameter int               DEPTH    = 11,
    parameter logic [DEPTH-1:0] INV_MASK = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        din,
    input  logic                        fault_en,
    input  logic [idx_width(DEPTH)-1:0] fault_stage,
    input  logic                        fault_val,
    output logic                        dout
);

    logic [DEPTH-1:0] stg_q;
    logic [DEPTH-1:0] stg_o;
    logic [DEPTH-1:0] stg_d;

    // The stuck-at forces the stage output seen downstream, not the stored bit,
    // so removing the fault immediately exposes the register contents again.
    always_comb begin
        stg_o = stg_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (fault_en && (int'(fault_stage) == i)) begin
                stg_o[i] = fault_val;
            end
        end
    end

    assign stg_d = {stg_o[DEPTH-2:0], din} ^ INV_MASK;
    assign dout  = stg_o[DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_q <= '0;
        end else begin
            stg_q <= stg_d;
        end
    end

endmodule

// File: rtl/path_delay_tester.sv
// rtl/path_delay_tester.sv - two-pattern launch/capture tester over CH parallel register paths
module path_delay_tester
    import path_test_pkg::*;
#(
    parameter int               CH       = 4,
    parameter int               DEPTH    = 11,
    parameter logic [DEPTH-1:0] INV_MASK = '0,
    parameter int               CAP_WAIT = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [CH-1:0]                v1,
    input  logic [CH-1:0]                v2,
    input  logic                         fault_en,
    input  logic [idx_width(CH)-1:0]     fault_ch,
    input  logic [idx_width(DEPTH)-1:0]  fault_stage,
    input  logic                         fault_val,
    input  logic                         clr_cnt,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [CH-1:0]                fail_mask,
    output logic [CH-1:0]                captured,
    output logic [FAIL_CNT_W-1:0]        fail_count
);

    localparam int              CNTW       = cnt_width((DEPTH > CAP_WAIT) ? DEPTH : CAP_WAIT);
    localparam logic [CNTW-1:0] INIT_LAST  = CNTW'(DEPTH - 1);
    localparam logic [CNTW-1:0] WAIT_LAST  = CNTW'((CAP_WAIT > 0) ? CAP_WAIT - 1 : 0);
    localparam logic            INV_PARITY = ^INV_MASK;

    state_t                  state_q;
    state_t                  state_d;
    logic [CNTW-1:0]         phase_q;
    logic [CNTW-1:0]         phase_d;
    logic [CH-1:0]           v1_q;
    logic [CH-1:0]           v2_q;
    logic [CH-1:0]           exp_q;
    logic [CH-1:0]           path_in;
    logic [CH-1:0]           path_out;
    logic [CH-1:0]           cap_diff;
    logic [CH-1:0]           captured_q;
    logic [CH-1:0]           fail_mask_q;
    logic                    pass_q;
    logic [FAIL_CNT_W-1:0]   fail_count_q;
    logic                    accept;
    logic                    launch_edge;
    logic                    capture_edge;
    logic                    count_edge;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                if (start && !abort) begin
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                if (phase_q == INIT_LAST) begin
                    state_d = ST_LAUNCH;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + CNTW'(1);
                end
            end
            ST_LAUNCH: begin
                phase_d = '0;
                state_d = (CAP_WAIT == 0) ? ST_CAPTURE : ST_WAIT;
            end
            ST_WAIT: begin
                if (phase_q == WAIT_LAST) begin
                    state_d = ST_CAPTURE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + CNTW'(1);
                end
            end
            ST_CAPTURE: state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            phase_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // v1 is frozen at acceptance; v2 drives the paths live during LAUNCH and is
    // then held so later input changes cannot disturb the transition in flight.
    always_comb begin
        case (state_q)
            ST_INIT:   path_in = v1_q;
            ST_LAUNCH: path_in = v2;
            default:   path_in = v2_q;
        endcase
    end

    assign accept       = (state_q == ST_IDLE) && start && !abort;
    assign launch_edge  = (state_q == ST_LAUNCH) && !abort;
    assign capture_edge = (state_q == ST_CAPTURE) && !abort;
    assign count_edge   = (state_q == ST_DONE) && !abort && !pass_q;
    assign cap_diff     = path_out ^ exp_q;

    for (genvar c = 0; c < CH; c++) begin : g_chan
        path_stage_chain #(
            .DEPTH    (DEPTH),
            .INV_MASK (INV_MASK)
        ) u_chain (
            .clk         (clk),
            .rst_n       (rst_n),
            .din         (path_in[c]),
            .fault_en    (fault_en && (int'(fault_ch) == c)),
            .fault_stage (fault_stage),
            .fault_val   (fault_val),
            .dout        (path_out[c])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= '0;
            v2_q        <= '0;
            exp_q       <= '0;
            captured_q  <= '0;
            fail_mask_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            if (accept) begin
                v1_q <= v1;
            end
            if (launch_edge) begin
                v2_q  <= v2;
                exp_q <= v2 ^ {CH{INV_PARITY}};
            end
            if (capture_edge) begin
                captured_q  <= path_out;
                fail_mask_q <= cap_diff;
                pass_q      <= (cap_diff == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_count_q <= '0;
        end else if (clr_cnt) begin
            fail_count_q <= '0;
        end else if (count_edge && (fail_count_q != {FAIL_CNT_W{1'b1}})) begin
            fail_count_q <= fail_count_q + FAIL_CNT_W'(1);
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE) && !abort;
    assign pass       = pass_q;
    assign fail_mask  = fail_mask_q;
    assign captured   = captured_q;
    assign fail_count = fail_count_q;

endmodule

// File: tb/tb_path_delay_tester.sv
// tb/tb_path_delay_tester.sv - scoreboard bench over three tester configurations
module tb_path_delay_tester;

    typedef struct packed {
        logic [3:0]  cap;
        logic [3:0]  fm;
        logic        p;
        logic [15:0] n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        fault_en = 1'b0;
    logic        fault_val = 1'b0;
    logic        clr_cnt = 1'b0;
    logic [3:0]  v1 = 4'h0;
    logic [3:0]  v2 = 4'h0;
    logic [1:0]  fault_ch = 2'd2;
    logic [3:0]  fault_stage = 4'd3;

    logic [2:0]  busy;
    logic [2:0]  done;
    logic [2:0]  pass;
    logic [3:0]  captured [3];
    logic [3:0]  fail_mask [3];
    logic [15:0] fail_count [3];

    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sbq [3][$];
    logic [2:0]  cnt_pend = 3'b000;
    logic [15:0] cnt_exp [3];
    int   done_seen [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    // dut0: at-speed default, dut1: three inverting stages, dut2: early capture
    path_delay_tester #(.CH(4), .DEPTH(11)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .v1(v1), .v2(v2),
        .fault_en(fault_en), .fault_ch(fault_ch), .fault_stage(fault_stage),
        .fault_val(fault_val), .clr_cnt(clr_cnt), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .fail_mask(fail_mask[0]), .captured(captured[0]),
        .fail_count(fail_count[0]));

    path_delay_tester #(.CH(4), .DEPTH(11), .INV_MASK(11'h007)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .v1(v1), .v2(v2),
        .fault_en(fault_en), .fault_ch(fault_ch), .fault_stage(fault_stage),
        .fault_val(fault_val), .clr_cnt(clr_cnt), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .fail_mask(fail_mask[1]), .captured(captured[1]),
        .fail_count(fail_count[1]));

    path_delay_tester #(.CH(4), .DEPTH(11), .CAP_WAIT(5)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .v1(v1), .v2(v2),
        .fault_en(fault_en), .fault_ch(fault_ch), .fault_stage(fault_stage),
        .fault_val(fault_val), .clr_cnt(clr_cnt), .busy(busy[2]), .done(done[2]),
        .pass(pass[2]), .fail_mask(fail_mask[2]), .captured(captured[2]),
        .fail_count(fail_count[2]));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    endtask

    task automatic push_exp(input int i, input logic [3:0] c, input logic [3:0] fm,
                            input logic p, input logic [15:0] n);
        exp_t e;
        e.cap = c;
        e.fm  = fm;
        e.p   = p;
        e.n   = n;
        sbq[i].push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (cnt_pend[i]) begin
                check($sformatf("dut%0d fail_count", i), 32'(fail_count[i]), 32'(cnt_exp[i]));
                cnt_pend[i] = 1'b0;
            end
            if (done[i]) begin
                done_seen[i]++;
                if (sbq[i].size() == 0) begin
                    check($sformatf("dut%0d unexpected done", i), 1, 0);
                end else begin
                    e = sbq[i].pop_front();
                    check($sformatf("dut%0d captured", i), 32'(captured[i]), 32'(e.cap));
                    check($sformatf("dut%0d fail_mask", i), 32'(fail_mask[i]), 32'(e.fm));
                    check($sformatf("dut%0d pass", i), 32'(pass[i]), 32'(e.p));
                    cnt_exp[i]  = e.n;
                    cnt_pend[i] = 1'b1;
                end
            end
        end
    end

    task automatic run_test(input logic [3:0] a1, input logic [3:0] a2,
                            input logic fe, input logic clr_at_done);
        int lat;
        int idle_wait;
        v1 = a1;
        v2 = a2;
        fault_en = fe;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done[0] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("dut0 start-to-done latency", lat, 24);
        if (clr_at_done) begin
            clr_cnt = 1'b1;
            @(negedge clk);
            clr_cnt = 1'b0;
        end
        idle_wait = 0;
        while (busy != 3'b000 && idle_wait < 50) begin
            @(negedge clk);
            idle_wait++;
        end
        check("return to idle", 32'(busy), 0);
        @(negedge clk);
        fault_en = 1'b0;
    endtask

    initial begin
        int ds0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset dut%0d busy", i), 32'(busy[i]), 0);
            check($sformatf("reset dut%0d done", i), 32'(done[i]), 0);
            check($sformatf("reset dut%0d pass", i), 32'(pass[i]), 0);
            check($sformatf("reset dut%0d captured", i), 32'(captured[i]), 0);
            check($sformatf("reset dut%0d fail_mask", i), 32'(fail_mask[i]), 0);
            check($sformatf("reset dut%0d fail_count", i), 32'(fail_count[i]), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // rising launch on every channel
        push_exp(0, 4'hF, 4'h0, 1'b1, 16'd0);
        push_exp(1, 4'h0, 4'h0, 1'b1, 16'd0);
        push_exp(2, 4'h0, 4'hF, 1'b0, 16'd1);
        run_test(4'h0, 4'hF, 1'b0, 1'b0);

        push_exp(0, 4'hA, 4'h0, 1'b1, 16'd0);
        push_exp(1, 4'h5, 4'h0, 1'b1, 16'd0);
        push_exp(2, 4'h0, 4'hA, 1'b0, 16'd2);
        run_test(4'h0, 4'hA, 1'b0, 1'b0);

        // stuck-at-0 on channel 2, stage 3
        push_exp(0, 4'hB, 4'h4, 1'b0, 16'd1);
        push_exp(1, 4'h0, 4'h0, 1'b1, 16'd0);
        push_exp(2, 4'h0, 4'hF, 1'b0, 16'd3);
        run_test(4'h0, 4'hF, 1'b1, 1'b0);

        push_exp(0, 4'h3, 4'h0, 1'b1, 16'd1);
        push_exp(1, 4'hC, 4'h0, 1'b1, 16'd0);
        push_exp(2, 4'h5, 4'h6, 1'b0, 16'd4);
        run_test(4'h5, 4'h3, 1'b0, 1'b0);

        // abort while in WAIT
        ds0 = done_seen[0] + done_seen[1] + done_seen[2];
        v1 = 4'h0;
        v2 = 4'hF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        check("busy before abort", 32'(busy), 32'h7);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("busy after abort", 32'(busy), 0);
        repeat (30) @(negedge clk);
        check("no done after abort", done_seen[0] + done_seen[1] + done_seen[2], ds0);
        check("fail_count after abort", 32'(fail_count[0]), 1);

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start+abort busy", 32'(busy), 0);
        repeat (30) @(negedge clk);
        check("no done after start+abort", done_seen[0] + done_seen[1] + done_seen[2], ds0);

        // saturation
        force u_dut0.fail_count_q = 16'hFFFF;
        @(negedge clk);
        release u_dut0.fail_count_q;
        @(negedge clk);
        check("preloaded fail_count", 32'(fail_count[0]), 32'hFFFF);
        push_exp(0, 4'hB, 4'h4, 1'b0, 16'hFFFF);
        push_exp(1, 4'h0, 4'h0, 1'b1, 16'd0);
        push_exp(2, 4'h0, 4'hF, 1'b0, 16'd5);
        run_test(4'h0, 4'hF, 1'b1, 1'b0);

        // clear coincident with a failing DONE
        push_exp(0, 4'hB, 4'h4, 1'b0, 16'd0);
        push_exp(1, 4'h0, 4'h0, 1'b1, 16'd0);
        push_exp(2, 4'h0, 4'hF, 1'b0, 16'd6);
        run_test(4'h0, 4'hF, 1'b1, 1'b1);
        check("dut2 fail_count after clear", 32'(fail_count[2]), 0);

        // reset in the middle of a test
        ds0 = done_seen[0] + done_seen[1] + done_seen[2];
        v1 = 4'h0;
        v2 = 4'h6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("no done after mid-test reset", done_seen[0] + done_seen[1] + done_seen[2], ds0);
        check("busy after mid-test reset", 32'(busy), 0);
        check("captured after mid-test reset", 32'(captured[0]), 0);
        check("fail_mask after mid-test reset", 32'(fail_mask[0]), 0);

        for (int i = 0; i < 3; i++) begin
            check($sformatf("dut%0d scoreboard drained", i), sbq[i].size(), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
